piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer with a valid/ready load interface.
//  Bit timing is paced by a shift_en tick. Bit order is selectable per word and an
//  optional parity bit can be appended. Sits between a word-wide producer (FIFO or
//  register bank) and a bit-serial line driver. Back-to-back words stream with no idle gap.
// PARAMETERS
//  WIDTH       8   data bits per word; legal range 2..64
//  PARITY      0   0 = none, 1 = even parity bit appended, 2 = odd parity bit appended
//  IDLE_LEVEL  0   level driven on serial_out whenever no frame is active
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      asynchronous active-low reset
//  shift_en      in   1      bit-rate tick; all loads and bit advances occur only on edges where it is 1
//  in_valid      in   1      parallel_in holds a word to send
//  in_ready      out  1      combinational; block accepts a word this cycle
//  parallel_in   in   WIDTH  data word; sampled only on acceptance
//  lsb_first     in   1      bit order for this word (1 = bit 0 first); sampled on acceptance
//  serial_out    out  1      registered serial bit
//  serial_valid  out  1      registered; serial_out carries a frame bit
//  frame_start   out  1      registered; 1 while the first bit of a frame is on serial_out
//  frame_end     out  1      registered; 1 while the last bit of a frame (parity if enabled) is on serial_out
//  busy          out  1      registered; equals serial_valid
// BEHAVIOUR
//  - FLEN = WIDTH + (PARITY != 0). Bit counter width = $clog2(FLEN).
//  - States: IDLE and SHIFT.
//  - Reset (reset_n low, async): state = IDLE, counter = 0, shift register = 0,
//    serial_out = IDLE_LEVEL, serial_valid = frame_start = frame_end = busy = 0.
//    in_ready is forced to 0 while reset_n is low.
//  - in_ready = reset_n & shift_en & ((state == IDLE) | (state == SHIFT & cnt == FLEN-1)).
//  - Accept = in_valid & in_ready, evaluated at a rising edge. On accept:
//      - Latch word, order and parity bit (^parallel_in, inverted when PARITY = 2).
//      - serial_out <= first bit (bit WIDTH-1, or bit 0 if lsb_first).
//      - serial_valid <= 1, frame_start <= 1, cnt <= 0, state <= SHIFT.
//    Latency: the first bit is visible in the cycle after the accept edge.
//  - In SHIFT, on an edge with shift_en = 1 and cnt < FLEN-1:
//      - Drive the next bit and increment cnt. Clear frame_start.
//      - Data bits are in latched order. The parity bit follows the last data bit.
//      - frame_end <= 1 when the bit driven has index FLEN-1.
//  - In SHIFT, on an edge with shift_en = 1 and cnt = FLEN-1:
//      - If accept: start the new frame as above, with no gap. frame_start = 1, frame_end = 0.
//      - Otherwise: state <= IDLE, serial_out <= IDLE_LEVEL, and all flags clear.
//  - shift_en = 0: all state and outputs hold. Each bit lasts exactly one shift_en period.
//  - in_valid with in_ready = 0: ignored, no sampling. The producer holds its word until accepted.
//  - Changes to parallel_in or lsb_first mid-frame have no effect on the frame in flight.
//  - Reset asserted mid-frame aborts the frame immediately. No partial-frame completion after release.
//  - WIDTH = 64 and FLEN = 65 must count correctly, with no counter wrap before FLEN-1.
// TESTING
//  1. WIDTH=8, PARITY=0, shift_en=1, word 8'hA5, lsb_first=0
//     -> serial_out 1,0,1,0,0,1,0,1 on 8 cycles; frame_start on bit 1; frame_end on bit 8; then IDLE_LEVEL.
//  2. Same word with lsb_first=1 -> 1,0,1,0,0,1,0,1 (8'hA5 is bit-reversal symmetric).
//     Word 8'h01 -> 1,0,0,0,0,0,0,0.
//  3. PARITY=1, word 8'h07 -> 8 data bits, then parity 1 as the 9th bit with frame_end.
//     PARITY=2 -> parity 0.
//  4. in_valid held high with words 8'h12 then 8'h34 -> 16 contiguous valid bits.
//     in_ready pulses only on the last-bit cycle. frame_start on bits 1 and 9.
//  5. shift_en high one cycle in four, word 8'hF0 -> each bit held 4 cycles.
//     in_valid with shift_en=0 is not accepted.
//  6. reset_n low after bit 3 of 8'hC3 -> outputs go to reset values immediately.
//     After release, IDLE with in_ready following shift_en.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready word load, shift_en bit pacing,
// per-word bit order and an optional even/odd parity bit after the data bits.
//
// state   | meaning
// S_IDLE  | no frame on the line; serial_out sits at IDLE_LEVEL
// S_SHIFT | a frame bit is on serial_out; r_cnt is the index of that bit
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY     = 0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             lsb_first,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned   FLEN        = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int unsigned   CW          = $clog2(FLEN);
  localparam logic [CW-1:0] CNT_LAST    = CW'(FLEN - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(FLEN - 2);
  localparam logic [CW-1:0] CNT_DLAST   = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic             r_lsb, w_lsb_nxt;
  logic             r_par, w_par_nxt;
  logic             r_sout, w_sout_nxt;
  logic             r_sval, w_sval_nxt;
  logic             r_fs, w_fs_nxt;
  logic             r_fe, w_fe_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_par_in;

  assign w_last   = (r_cnt == CNT_LAST);
  assign w_par_in = (^parallel_in) ^ ((PARITY == 2) ? 1'b1 : 1'b0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (shift_en && w_last && !w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = reset_n & shift_en & ((r_state == S_IDLE) | ((r_state == S_SHIFT) & w_last));
    w_accept   = in_valid & in_ready;
    w_cnt_nxt  = r_cnt;
    w_sreg_nxt = r_sreg;
    w_lsb_nxt  = r_lsb;
    w_par_nxt  = r_par;
    w_sout_nxt = r_sout;
    w_sval_nxt = r_sval;
    w_fs_nxt   = r_fs;
    w_fe_nxt   = r_fe;
    if (w_accept) begin
      w_cnt_nxt  = '0;
      w_sreg_nxt = parallel_in;
      w_lsb_nxt  = lsb_first;
      w_par_nxt  = w_par_in;
      w_sout_nxt = lsb_first ? parallel_in[0] : parallel_in[WIDTH-1];
      w_sval_nxt = 1'b1;
      w_fs_nxt   = 1'b1;
      w_fe_nxt   = 1'b0;
    end else if (shift_en && (r_state == S_SHIFT) && !w_last) begin
      w_cnt_nxt  = r_cnt + CW'(1);
      w_sreg_nxt = r_lsb ? (r_sreg >> 1) : (r_sreg << 1);
      // The shift register still holds the bit just sent at one end, so look one in.
      if ((PARITY != 0) && (r_cnt == CNT_DLAST)) w_sout_nxt = r_par;
      else w_sout_nxt = r_lsb ? r_sreg[1] : r_sreg[WIDTH-2];
      w_fs_nxt   = 1'b0;
      w_fe_nxt   = (r_cnt == CNT_PRELAST);
    end else if (shift_en && (r_state == S_SHIFT)) begin
      w_cnt_nxt  = '0;
      w_sout_nxt = IDLE_LEVEL;
      w_sval_nxt = 1'b0;
      w_fs_nxt   = 1'b0;
      w_fe_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_sreg <= '0;
      r_lsb  <= 1'b0;
      r_par  <= 1'b0;
      r_sout <= IDLE_LEVEL;
      r_sval <= 1'b0;
      r_fs   <= 1'b0;
      r_fe   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sreg <= w_sreg_nxt;
      r_lsb  <= w_lsb_nxt;
      r_par  <= w_par_nxt;
      r_sout <= w_sout_nxt;
      r_sval <= w_sval_nxt;
      r_fs   <= w_fs_nxt;
      r_fe   <= w_fe_nxt;
    end
  end

  assign serial_out   = r_sout;
  assign serial_valid = r_sval;
  assign frame_start  = r_fs;
  assign frame_end    = r_fe;
  assign busy         = r_sval;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four instances (8-bit none/even/odd parity, 64-bit even)
// share one stimulus stream; directed scenarios plus a queue-based frame model.
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        shift_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        lsb_first = 1'b0;
  logic [63:0] pin = '0;
  logic        rdy[4], sout[4], sval[4], fs[4], fe[4], bsy[4];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mq[4][$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .PARITY(0), .IDLE_LEVEL(1'b0)) u_w8p0 (
    .clk(clk), .reset_n(reset_n), .shift_en(shift_en), .in_valid(in_valid), .in_ready(rdy[0]),
    .parallel_in(pin[7:0]), .lsb_first(lsb_first), .serial_out(sout[0]), .serial_valid(sval[0]),
    .frame_start(fs[0]), .frame_end(fe[0]), .busy(bsy[0]));
  piso_serializer #(.WIDTH(8), .PARITY(1), .IDLE_LEVEL(1'b0)) u_w8p1 (
    .clk(clk), .reset_n(reset_n), .shift_en(shift_en), .in_valid(in_valid), .in_ready(rdy[1]),
    .parallel_in(pin[7:0]), .lsb_first(lsb_first), .serial_out(sout[1]), .serial_valid(sval[1]),
    .frame_start(fs[1]), .frame_end(fe[1]), .busy(bsy[1]));
  piso_serializer #(.WIDTH(8), .PARITY(2), .IDLE_LEVEL(1'b1)) u_w8p2 (
    .clk(clk), .reset_n(reset_n), .shift_en(shift_en), .in_valid(in_valid), .in_ready(rdy[2]),
    .parallel_in(pin[7:0]), .lsb_first(lsb_first), .serial_out(sout[2]), .serial_valid(sval[2]),
    .frame_start(fs[2]), .frame_end(fe[2]), .busy(bsy[2]));
  piso_serializer #(.WIDTH(64), .PARITY(1), .IDLE_LEVEL(1'b0)) u_w64p1 (
    .clk(clk), .reset_n(reset_n), .shift_en(shift_en), .in_valid(in_valid), .in_ready(rdy[3]),
    .parallel_in(pin), .lsb_first(lsb_first), .serial_out(sout[3]), .serial_valid(sval[3]),
    .frame_start(fs[3]), .frame_end(fe[3]), .busy(bsy[3]));

  function automatic int wid(int k);
    return (k == 3) ? 64 : 8;
  endfunction
  function automatic int par(int k);
    return (k == 0) ? 0 : ((k == 2) ? 2 : 1);
  endfunction
  function automatic int flen(int k);
    return wid(k) + ((par(k) != 0) ? 1 : 0);
  endfunction
  function automatic logic idl(int k);
    return (k == 2);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; shift_en = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0; shift_en = 1'b1; in_valid = 1'b1; pin = {$urandom, $urandom};
    #2;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rdy[k] !== 1'b0 || sval[k] !== 1'b0 || fs[k] !== 1'b0 || fe[k] !== 1'b0 ||
          bsy[k] !== 1'b0 || sout[k] !== idl(k)) begin
        n_err++;
        $display("FAIL reset inst%0d: got rdy=%b out=%b v=%b fs=%b fe=%b busy=%b, want out=%b rest 0",
                 k, rdy[k], sout[k], sval[k], fs[k], fe[k], bsy[k], idl(k));
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sval[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: got v=%b rdy=%b, want 0 0", sval[0], rdy[0]);
    end
    reset_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_order();
    logic [7:0] words[3] = '{8'hA5, 8'hA5, 8'h01};
    logic       lsbs[3]  = '{1'b0, 1'b1, 1'b1};
    logic [7:0] w;
    logic       eb;
    for (int v = 0; v < 3; v++) begin
      do_reset();
      w = words[v];
      shift_en = 1'b1; in_valid = 1'b1; pin = {56'h0, w}; lsb_first = lsbs[v];
      @(posedge clk); #1;
      in_valid = 1'b0; pin = {$urandom, $urandom}; lsb_first = ~lsbs[v];
      for (int i = 0; i < 9; i++) begin
        eb = (i == 8) ? 1'b0 : (lsbs[v] ? w[i] : w[7-i]);
        n_cmp++;
        if (sout[0] !== eb || sval[0] !== (i < 8) || bsy[0] !== (i < 8) ||
            fs[0] !== (i == 0) || fe[0] !== (i == 7)) begin
          n_err++;
          $display("FAIL order w=%h lsb=%b pos%0d: got out=%b v=%b fs=%b fe=%b, want out=%b v=%b fs=%b fe=%b",
                   w, lsbs[v], i, sout[0], sval[0], fs[0], fe[0], eb, (i < 8), (i == 0), (i == 7));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] w = 8'h07;
    logic       pexp[2] = '{1'b1, 1'b0};
    logic       eb;
    do_reset();
    shift_en = 1'b1; in_valid = 1'b1; pin = {56'h0, w}; lsb_first = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 1; k < 3; k++) begin
        eb = (i < 8) ? w[7-i] : ((i == 8) ? pexp[k-1] : idl(k));
        n_cmp++;
        if (sout[k] !== eb || sval[k] !== (i < 9) || fe[k] !== (i == 8) || fs[k] !== (i == 0)) begin
          n_err++;
          $display("FAIL parity inst%0d pos%0d: got out=%b v=%b fe=%b fs=%b, want out=%b v=%b fe=%b fs=%b",
                   k, i, sout[k], sval[k], fe[k], fs[k], eb, (i < 9), (i == 8), (i == 0));
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (sval[0] !== 1'b0) begin
          n_err++;
          $display("FAIL parity_none_len: got v=%b at pos 8, want 0", sval[0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic       eb;
    do_reset();
    shift_en = 1'b1; lsb_first = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      in_valid = (c <= 8);
      pin = (c < 8) ? 64'h12 : 64'h34;
      #1;
      n_cmp++;
      if (rdy[0] !== (c == 0 || c == 8 || c == 16)) begin
        n_err++;
        $display("FAIL b2b_ready c%0d: got %b, want %b", c, rdy[0], (c == 0 || c == 8 || c == 16));
      end
      @(posedge clk); #1;
      w = (c < 8) ? 8'h12 : 8'h34;
      eb = (c < 16) ? w[7 - (c % 8)] : 1'b0;
      n_cmp++;
      if (sout[0] !== eb || sval[0] !== (c < 16) || fs[0] !== (c < 16 && c % 8 == 0) ||
          fe[0] !== (c < 16 && c % 8 == 7)) begin
        n_err++;
        $display("FAIL b2b_bits pos%0d: got out=%b v=%b fs=%b fe=%b, want out=%b v=%b fs=%b fe=%b",
                 c, sout[0], sval[0], fs[0], fe[0], eb, (c < 16), (c < 16 && c % 8 == 0),
                 (c < 16 && c % 8 == 7));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_shift_en();
    logic [7:0] w = 8'hF0;
    logic       eb;
    do_reset();
    in_valid = 1'b1; pin = {56'h0, w}; lsb_first = 1'b0; shift_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (rdy[0] !== 1'b0) begin
        n_err++;
        $display("FAIL gate_ready c%0d: got %b, want 0", c, rdy[0]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (sval[0] !== 1'b0) begin
        n_err++;
        $display("FAIL gate_noaccept c%0d: got v=%b, want 0", c, sval[0]);
      end
    end
    shift_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; shift_en = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      eb = (c < 32) ? w[7 - c/4] : 1'b0;
      n_cmp++;
      if (sout[0] !== eb || sval[0] !== (c < 32) || fs[0] !== (c < 4) || fe[0] !== (c >= 28 && c < 32)) begin
        n_err++;
        $display("FAIL gate_bits cyc%0d: got out=%b v=%b fs=%b fe=%b, want out=%b v=%b fs=%b fe=%b",
                 c, sout[0], sval[0], fs[0], fe[0], eb, (c < 32), (c < 4), (c >= 28 && c < 32));
      end
      shift_en = (c % 4 == 3);
      @(posedge clk); #1;
    end
    shift_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] w = 8'hC3;
    do_reset();
    shift_en = 1'b1; in_valid = 1'b1; pin = {56'h0, w}; lsb_first = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (sout[0] !== w[5] || sval[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_bit3: got out=%b v=%b, want out=%b v=1", sout[0], sval[0], w[5]);
    end
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (sout[k] !== idl(k) || sval[k] !== 1'b0 || fs[k] !== 1'b0 || fe[k] !== 1'b0 ||
          bsy[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_abort inst%0d: got out=%b v=%b fs=%b fe=%b busy=%b rdy=%b, want out=%b rest 0",
                 k, sout[k], sval[k], fs[k], fe[k], bsy[k], rdy[k], idl(k));
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      shift_en = c[0];
      #1;
      n_cmp++;
      if (rdy[0] !== shift_en) begin
        n_err++;
        $display("FAIL midrst_ready c%0d: got %b, want %b", c, rdy[0], shift_en);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (sval[0] !== 1'b0 || sout[0] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_idle c%0d: got v=%b out=%b, want 0 0", c, sval[0], sout[0]);
      end
    end
    shift_en = 1'b0;
  endtask

  task automatic test_random();
    int   sz;
    logic eb, p;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      shift_en  = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      lsb_first = $urandom_range(0, 1) == 1;
      pin       = {$urandom, $urandom};
      if (!reset_n) for (int k = 0; k < 4; k++) mq[k].delete();
      #1;
      for (int k = 0; k < 4; k++) begin
        eb = reset_n & shift_en & (mq[k].size() <= 1);
        n_cmp++;
        if (rdy[k] !== eb) begin
          n_err++;
          $display("FAIL rand_ready inst%0d cyc%0d: got %b, want %b", k, cyc, rdy[k], eb);
        end
      end
      @(posedge clk);
      if (reset_n && shift_en) begin
        for (int k = 0; k < 4; k++) begin
          if (mq[k].size() <= 1 && in_valid) begin
            mq[k].delete();
            for (int j = 0; j < wid(k); j++) mq[k].push_back(lsb_first ? pin[j] : pin[wid(k)-1-j]);
            if (par(k) != 0) begin
              p = (par(k) == 2);
              for (int j = 0; j < wid(k); j++) p = p ^ pin[j];
              mq[k].push_back(p);
            end
          end else if (mq[k].size() > 0) begin
            void'(mq[k].pop_front());
          end
        end
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        sz = mq[k].size();
        eb = (sz > 0) ? mq[k][0] : idl(k);
        n_cmp++;
        if (sout[k] !== eb || sval[k] !== (sz > 0) || bsy[k] !== (sz > 0) ||
            fs[k] !== (sz == flen(k)) || fe[k] !== (sz == 1)) begin
          n_err++;
          $display("FAIL rand_out inst%0d cyc%0d: got out=%b v=%b busy=%b fs=%b fe=%b, want out=%b v=%b fs=%b fe=%b",
                   k, cyc, sout[k], sval[k], bsy[k], fs[k], fe[k], eb, (sz > 0), (sz == flen(k)), (sz == 1));
        end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_order();
    test_parity();
    test_back_to_back();
    test_shift_en();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
